// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller bundle; master = controller, slave = pipeline datapath.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs, id_rt, ex_wreg;
  logic ex_memtoreg, ex_mispredict, ex_div, div_done, mem_stall;
  logic div_start, pc_en;
  logic en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  modport master (
    input  id_rs, id_rt, ex_wreg, ex_memtoreg, ex_mispredict, ex_div, div_done, mem_stall,
    output div_start, pc_en, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw,
    output stall_cnt, flush_cnt
  );
  modport slave (
    output id_rs, id_rt, ex_wreg, ex_memtoreg, ex_mispredict, ex_div, div_done, mem_stall,
    input  div_start, pc_en, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw,
    input  stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline stall/flush control with divide sequencing and perf counters.
module pipe_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic w_div_hold, w_load_use, w_flush;
  logic [8:0] w_ctl;
  assign w_div_hold = bus.ex_div && r_state != DONE;
  assign w_load_use = bus.ex_memtoreg && bus.ex_wreg != {REG_W{1'b0}} &&
                      (bus.ex_wreg == bus.id_rs || bus.ex_wreg == bus.id_rt);
  assign w_flush = rst && !bus.mem_stall && !w_div_hold && bus.ex_mispredict;
  // {pc_en, en_fd, en_de, en_em, en_mw, clr_fd, clr_de, clr_em, clr_mw}
  always_comb
    w_ctl = !rst            ? 9'b0_0000_1111 :
            bus.mem_stall   ? 9'b0_0000_0001 :
            w_div_hold      ? 9'b0_0001_0010 :
            bus.ex_mispredict ? 9'b1_1111_1100 :
            w_load_use      ? 9'b0_0011_0100 :
                              9'b1_1111_0000;
  assign {bus.pc_en, bus.en_fd, bus.en_de, bus.en_em, bus.en_mw,
          bus.clr_fd, bus.clr_de, bus.clr_em, bus.clr_mw} = w_ctl;
  assign bus.div_start = rst && r_state == IDLE && bus.ex_div && !bus.mem_stall;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= r_state == IDLE ? ((bus.ex_div && !bus.mem_stall) ? BUSY : IDLE) :
                 r_state == BUSY ? (bus.div_done ? DONE : BUSY) :
                 (bus.mem_stall ? DONE : IDLE);
      if (!bus.pc_en && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios for the hazard controller, 4-bit counters to reach saturation.
module tb_pipe_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam logic [8:0] CTL_RST  = 9'b0_0000_1111;
  localparam logic [8:0] CTL_MEM  = 9'b0_0000_0001;
  localparam logic [8:0] CTL_NORM = 9'b1_1111_0000;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int starts;
  logic [CNT_W-1:0] exp_stall, exp_flush;
  pipe_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();
  pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  wire [8:0] ctl = {bus.pc_en, bus.en_fd, bus.en_de, bus.en_em, bus.en_mw,
                    bus.clr_fd, bus.clr_de, bus.clr_em, bus.clr_mw};

  always @(posedge clk)
    if (rst) assert (!(bus.ex_div && bus.ex_mispredict)) else $error("illegal ex_div together with ex_mispredict");

  task automatic step(input logic r, ms, dv, dd, mp, mt, input logic [REG_W-1:0] wr, rs, rt);
    @(negedge clk);
    rst = r; bus.mem_stall = ms; bus.ex_div = dv; bus.div_done = dd; bus.ex_mispredict = mp;
    bus.ex_memtoreg = mt; bus.ex_wreg = wr; bus.id_rs = rs; bus.id_rt = rt;
    #1;
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== CTL_RST) begin errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RST); end
    checks++; if (bus.div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start: got %b want 0", bus.div_start); end
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
    exp_stall = 0; exp_flush = 0;
  endtask

  task automatic test_normal();
    idle();
    checks++; if (ctl !== CTL_NORM) begin errors++; $display("FAIL normal_ctl: got %b want %b", ctl, CTL_NORM); end
    checks++; if (bus.div_start !== 1'b0) begin errors++; $display("FAIL normal_div_start: got %b want 0", bus.div_start); end
    idle();
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL normal_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_load_use();
    step(1, 0, 0, 0, 0, 1, 8, 0, 8);
    checks++; if ({bus.pc_en, bus.en_fd, bus.clr_de, bus.en_em, bus.en_mw} !== 5'b00111) begin errors++; $display("FAIL load_use_rt: got pc/fd/clr_de/em/mw=%b want 00111", {bus.pc_en, bus.en_fd, bus.clr_de, bus.en_em, bus.en_mw}); end
    exp_stall++;
    step(1, 0, 0, 0, 0, 1, 3, 3, 5);
    checks++; if ({bus.pc_en, bus.en_fd, bus.clr_de} !== 3'b001) begin errors++; $display("FAIL load_use_rs: got pc/fd/clr_de=%b want 001", {bus.pc_en, bus.en_fd, bus.clr_de}); end
    exp_stall++;
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    checks++; if (ctl !== CTL_NORM) begin errors++; $display("FAIL load_use_r0: got %b want %b", ctl, CTL_NORM); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL load_use_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_divide();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, i == 4, 0, 0, 0, 0, 0);
      checks++; if (bus.div_start !== (i == 0)) begin errors++; $display("FAIL div_start_c%0d: got %b want %b", i, bus.div_start, i == 0); end
      if (i < 5) begin
        checks++; if ({bus.pc_en, bus.en_fd, bus.en_de, bus.clr_em, bus.en_mw} !== 5'b00011) begin errors++; $display("FAIL div_hold_c%0d: got pc/fd/de/clr_em/mw=%b want 00011", i, {bus.pc_en, bus.en_fd, bus.en_de, bus.clr_em, bus.en_mw}); end
        exp_stall++;
      end else begin
        checks++; if (ctl !== CTL_NORM) begin errors++; $display("FAIL div_done_ctl: got %b want %b", ctl, CTL_NORM); end
      end
    end
    idle();
    checks++; if (ctl !== CTL_NORM || bus.div_start !== 1'b0) begin errors++; $display("FAIL div_after: got ctl %b start %b want %b 0", ctl, bus.div_start, CTL_NORM); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL div_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_mem_stall_div();
    starts = 0;
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (ctl !== CTL_NORM) begin errors++; $display("FAIL stray_done: got %b want %b", ctl, CTL_NORM); end
    step(1, 1, 1, 0, 0, 0, 0, 0, 0);
    starts += int'(bus.div_start);
    checks++; if (ctl !== CTL_MEM || bus.div_start !== 1'b0) begin errors++; $display("FAIL idle_mem_stall: got ctl %b start %b want %b 0", ctl, bus.div_start, CTL_MEM); end
    exp_stall++;
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    starts += int'(bus.div_start);
    checks++; if (bus.div_start !== 1'b1) begin errors++; $display("FAIL ms_div_start: got %b want 1", bus.div_start); end
    exp_stall++;
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    starts += int'(bus.div_start);
    checks++; if (bus.pc_en !== 1'b0 || bus.clr_em !== 1'b1) begin errors++; $display("FAIL ms_busy: got pc %b clr_em %b want 0 1", bus.pc_en, bus.clr_em); end
    exp_stall++;
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 1, i == 1, 0, 0, 0, 0, 0);
      starts += int'(bus.div_start);
      checks++; if (ctl !== CTL_MEM) begin errors++; $display("FAIL ms_stall_c%0d: got %b want %b", i, ctl, CTL_MEM); end
      exp_stall++;
    end
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    starts += int'(bus.div_start);
    checks++; if (ctl !== CTL_NORM || bus.div_start !== 1'b0) begin errors++; $display("FAIL ms_done_hold: got ctl %b start %b want %b 0", ctl, bus.div_start, CTL_NORM); end
    idle();
    checks++; if (starts !== 1) begin errors++; $display("FAIL ms_start_count: got %0d want 1", starts); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL ms_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_mispredict_load_use();
    step(1, 0, 0, 0, 1, 1, 8, 0, 8);
    checks++; if ({bus.pc_en, bus.clr_fd, bus.clr_de, bus.en_em, bus.en_mw} !== 5'b11111) begin errors++; $display("FAIL mp_ctl: got pc/clr_fd/clr_de/em/mw=%b want 11111", {bus.pc_en, bus.clr_fd, bus.clr_de, bus.en_em, bus.en_mw}); end
    exp_flush++;
    idle();
    checks++; if (bus.flush_cnt !== exp_flush) begin errors++; $display("FAIL mp_flush_cnt: got %0d want %0d", bus.flush_cnt, exp_flush); end
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL mp_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_reset_mid_busy();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.div_start !== 1'b0 || bus.pc_en !== 1'b0) begin errors++; $display("FAIL rb_busy: got start %b pc %b want 0 0", bus.div_start, bus.pc_en); end
    #2 rst = 1'b0;
    #1;
    checks++; if (ctl !== CTL_RST || bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin errors++; $display("FAIL rb_async: got ctl %b cnt %0d/%0d want %b 0/0", ctl, bus.stall_cnt, bus.flush_cnt, CTL_RST); end
    exp_stall = 0; exp_flush = 0;
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (bus.div_start !== 1'b1) begin errors++; $display("FAIL rb_new_start: got %b want 1", bus.div_start); end
    exp_stall++;
    step(1, 0, 1, 1, 0, 0, 0, 0, 0);
    exp_stall++;
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    checks++; if (ctl !== CTL_NORM) begin errors++; $display("FAIL rb_done: got %b want %b", ctl, CTL_NORM); end
    idle();
    checks++; if (bus.stall_cnt !== exp_stall) begin errors++; $display("FAIL rb_stall_cnt: got %0d want %0d", bus.stall_cnt, exp_stall); end
  endtask

  task automatic test_saturation();
    repeat (20) step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    checks++; if (bus.stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall: got %0d want 15", bus.stall_cnt); end
    repeat (18) step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    idle();
    checks++; if (bus.flush_cnt !== 4'hF) begin errors++; $display("FAIL sat_flush: got %0d want 15", bus.flush_cnt); end
    checks++; if (bus.stall_cnt !== 4'hF) begin errors++; $display("FAIL sat_stall_hold: got %0d want 15", bus.stall_cnt); end
  endtask

  initial begin
    rst = 1'b0;
    bus.mem_stall = 0; bus.ex_div = 0; bus.div_done = 0; bus.ex_mispredict = 0;
    bus.ex_memtoreg = 0; bus.ex_wreg = 0; bus.id_rs = 0; bus.id_rt = 0;
    exp_stall = 0; exp_flush = 0;
    test_reset();
    test_normal();
    test_load_use();
    test_divide();
    test_mem_stall_div();
    test_mispredict_load_use();
    test_reset_mid_busy();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5: register-address width.
REQ-002 SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port id_rs, id_rt, input, REG_W each: source registers of the instruction in ID.
REQ-006 SHALL have port ex_memtoreg, input, 1: the instruction in EX is a load.
REQ-007 SHALL have port ex_wreg, input, REG_W: destination register of the instruction in EX.
REQ-008 SHALL have port ex_mispredict, input, 1: a branch in EX resolved against its prediction.
REQ-009 SHALL have port ex_div, input, 1: the instruction in EX is a multi-cycle divide.
REQ-010 SHALL have port div_done, input, 1: one-cycle pulse from the divider; the result is valid and held.
REQ-011 SHALL have port mem_stall, input, 1: data memory is not ready, so the MEM stage must wait.
REQ-012 SHALL have port div_start, output, 1: one-cycle start pulse to the divider.
REQ-013 SHALL have port pc_en, output, 1: PC register enable.
REQ-014 SHALL have ports en_fd/clr_fd, en_de/clr_de, en_em/clr_em, en_mw/clr_mw, output, 1 each: enable and clear for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, in which clear has priority over enable.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each: performance counters.

Function
REQ-016 SHALL run a divide FSM with states IDLE, BUSY and DONE.
- IDLE->BUSY when ex_div=1 and mem_stall=0.
- BUSY->DONE on div_done=1.
- DONE->IDLE unconditionally unless mem_stall=1; in that case it holds DONE.
REQ-017 SHALL drive div_start=1 combinationally only when state=IDLE, ex_div=1 and mem_stall=0, so exactly one pulse per divide.
REQ-018 SHALL define div_hold = ex_div and state!=DONE.
REQ-019 SHALL define load_use = ex_memtoreg and ex_wreg!=0 and (ex_wreg==id_rs or ex_wreg==id_rt).
REQ-020 SHALL resolve controls combinationally with priority mem_stall > div_hold > ex_mispredict > load_use > normal.
REQ-021 In the mem_stall case:
- pc_en=0 and en_fd=en_de=en_em=0.
- clr_mw=1, so no duplicate writeback.
- All other clears 0.
REQ-022 In the div_hold case:
- pc_en=en_fd=en_de=0.
- clr_em=1 (bubble).
- en_mw=1.
REQ-023 In the ex_mispredict case:
- pc_en=1 (redirect).
- clr_fd=1 and clr_de=1.
- en_em=en_mw=1.
- A load_use present in the same cycle is ignored, because the ID instruction is wrong-path.
REQ-024 In the load_use case:
- pc_en=en_fd=0.
- clr_de=1.
- en_em=en_mw=1.
REQ-025 In the normal case, SHALL drive all enables 1 and all clears 0.
REQ-026 SHALL increment stall_cnt in every cycle in which pc_en=0, saturating at all-ones.
REQ-027 SHALL increment flush_cnt once per cycle in which the mispredict case is selected, saturating at all-ones.
REQ-028 SHALL treat a div_done that arrives while not in BUSY as ignored.
REQ-029 SHALL treat ex_div=1 together with ex_mispredict=1 as illegal; the bench shall flag it with an assertion.
REQ-030 SHALL let a div_done that coincides with mem_stall=1 move BUSY->DONE; the DONE hold then keeps EX advancing correctly once mem_stall drops.

Reset
REQ-031 While rst=0:
- FSM=IDLE and stall_cnt=flush_cnt=0.
- div_start=0.
- pc_en and all en_* =0.
- All clr_* =1.
REQ-032 SHALL let reset assertion mid-divide (BUSY) force IDLE immediately, without waiting for div_done.
REQ-033 After rst deasserts, SHALL take its first state update on the next rising clk edge.

Verification
REQ-034 Load-use: ex_memtoreg=1, ex_wreg=8, id_rt=8 for 1 cycle -> pc_en=0, en_fd=0, clr_de=1, stall_cnt +1. With ex_wreg=0 instead -> no stall.
REQ-035 Divide: ex_div=1, then div_done after 4 cycles.
- div_start=1 only in the first cycle.
- clr_em=1 and pc_en=0 for 5 cycles.
- DONE cycle has all enables 1, then IDLE.
- stall_cnt=5.
REQ-036 Mispredict plus load-use in the same cycle -> clr_fd=1, clr_de=1, pc_en=1, flush_cnt +1, stall_cnt unchanged.
REQ-037 mem_stall=1 for 3 cycles during BUSY with div_done in the 2nd of them.
- clr_mw=1 and all other enables 0 for those 3 cycles.
- FSM holds DONE until mem_stall=0.
- Exactly one div_start overall.
REQ-038 rst=0 pulsed mid-BUSY -> IDLE asynchronously and counters 0. ex_div=1 after release -> a new div_start. Counter preset near all-ones -> saturates, does not wrap.
